// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised inter-stage pipeline register.
//
// DEPTH register stages are connected in series. Each stage has a valid bit.
// The block supports stall (hold), flush (kill) and bubble insertion. On a
// flush, and when a bubble enters (in_valid=0), only the payload bits selected
// by CTL_MASK are zeroed. A killed instruction therefore cannot write
// registers, memory or the PC, and the datapath bits are left as they were.
//
// Parameters:
//   WIDTH    payload width; the bus is indexed [0:WIDTH-1] and bit 0 is the MSB
//   DEPTH    number of stages in series (1..4)
//   CTL_MASK 1 = control bit (zeroed on flush/bubble), 0 = datapath bit
//   OCC_W    width of the occupancy output (2**OCC_W > DEPTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in         payload from the upstream stage
//   in_valid   the payload holds a real instruction
//   stall      hold all stages (the upstream stage must hold in)
//   flush      kill all stages (takes priority over stall)
//   out        payload of the last stage
//   out_valid  the last stage holds a real instruction
//   occupancy  number of valid stages, 0..DEPTH
//   stall_cnt  saturating count of stall cycles (only with PIPE_STATS_EN)
//   flush_cnt  saturating count of flush cycles (only with PIPE_STATS_EN)
//
// Optional feature: define PIPE_STATS_EN to build the stall/flush counters.
// When it is undefined, both counter outputs are tied to zero.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH    = 166,
  parameter int unsigned      DEPTH    = 1,
  parameter logic [0:WIDTH-1] CTL_MASK = '1,
  parameter int unsigned      OCC_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] in,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [0:WIDTH-1] out,
  output logic             out_valid,
  output logic [OCC_W-1:0] occupancy,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  logic [0:WIDTH-1] dataQ  [DEPTH];
  logic             validQ [DEPTH];
  logic [OCC_W-1:0] occQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dataQ[i]  <= '0;
        validQ[i] <= 1'b0;
      end
      occQ <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dataQ[i]  <= dataQ[i] & ~CTL_MASK;
        validQ[i] <= 1'b0;
      end
      occQ <= '0;
    end else if (!stall) begin
      // A bubble enters with its control bits cleared.
      dataQ[0]  <= in_valid ? in : (in & ~CTL_MASK);
      validQ[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        dataQ[i]  <= dataQ[i-1];
        validQ[i] <= validQ[i-1];
      end
      // Count what enters minus what leaves. This keeps occQ equal to the
      // popcount of validQ without a popcount tree.
      occQ <= occQ + OCC_W'(in_valid) - OCC_W'(validQ[DEPTH-1]);
    end
  end

  assign out       = dataQ[DEPTH-1];
  assign out_valid = validQ[DEPTH-1];
  assign occupancy = occQ;

`ifdef PIPE_STATS_EN
  logic [15:0] stallCntQ;
  logic [15:0] flushCntQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (flush && (flushCntQ != 16'hFFFF))
        flushCntQ <= flushCntQ + 16'd1;
      if (stall && !flush && (stallCntQ != 16'hFFFF))
        stallCntQ <= stallCntQ + 16'd1;
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [0:165] MASK4 = {149'b0, {17{1'b1}}};
  localparam logic [0:165] PAT4  = {32'h0000_1000, {117{1'b1}}, {17{1'b1}}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // u1: defaults (W166, D1, full mask) -- reset test and statistics test
  logic [0:165] in1, out1;
  logic in1V, st1, fl1, out1V;
  logic [2:0] occ1;
  logic [15:0] sc1, fc1;
  // u3: W32, D3 -- latency and occupancy
  logic [0:31] in3, out3;
  logic in3V, st3, fl3, out3V;
  logic [2:0] occ3;
  logic [15:0] sc3, fc3;
  // u2: W32, D2 -- stall
  logic [0:31] in2, out2;
  logic in2V, st2, fl2, out2V;
  logic [2:0] occ2;
  logic [15:0] sc2, fc2;
  // u4: W166, D1, partial mask -- flush and bubble
  logic [0:165] in4, out4;
  logic in4V, st4, fl4, out4V;
  logic [2:0] occ4;
  logic [15:0] sc4, fc4;

  pipe_stage_reg u1 (
    .clk(clk), .reset(reset), .in(in1), .in_valid(in1V), .stall(st1), .flush(fl1),
    .out(out1), .out_valid(out1V), .occupancy(occ1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .CTL_MASK(32'hFFFF_FFFF), .OCC_W(3)) u3 (
    .clk(clk), .reset(reset), .in(in3), .in_valid(in3V), .stall(st3), .flush(fl3),
    .out(out3), .out_valid(out3V), .occupancy(occ3), .stall_cnt(sc3), .flush_cnt(fc3));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .CTL_MASK(32'hFFFF_FFFF), .OCC_W(3)) u2 (
    .clk(clk), .reset(reset), .in(in2), .in_valid(in2V), .stall(st2), .flush(fl2),
    .out(out2), .out_valid(out2V), .occupancy(occ2), .stall_cnt(sc2), .flush_cnt(fc2));

  pipe_stage_reg #(.WIDTH(166), .DEPTH(1), .CTL_MASK(MASK4), .OCC_W(3)) u4 (
    .clk(clk), .reset(reset), .in(in4), .in_valid(in4V), .stall(st4), .flush(fl4),
    .out(out4), .out_valid(out4V), .occupancy(occ4), .stall_cnt(sc4), .flush_cnt(fc4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [165:0] obs, input logic [165:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    in1 = '1; in1V = 1'b1; st1 = 1'b0; fl1 = 1'b0;
    in3 = '0; in3V = 1'b0; st3 = 1'b0; fl3 = 1'b0;
    in2 = '0; in2V = 1'b0; st2 = 1'b0; fl2 = 1'b0;
    in4 = '0; in4V = 1'b0; st4 = 1'b0; fl4 = 1'b0;

    // 1. Reset is held across 3 edges, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", out1, '0);
      chk("rst_valid", out1V, 1'b0);
      chk("rst_occ", occ1, 3'd0);
    end
    chk("rst_scnt", sc1, 16'd0);
    chk("rst_fcnt", fc1, 16'd0);
    reset = 1'b1;
    tick();
    chk("rel_out", out1, {166{1'b1}});
    chk("rel_valid", out1V, 1'b1);
    chk("rel_occ", occ1, 3'd1);
    in1V = 1'b0;
    in1 = '0;

    // 2. Latency and occupancy with DEPTH=3.
    in3 = 32'hAAAA_0001; in3V = 1'b1;
    tick();
    chk("lat_occ1", occ3, 3'd1);
    chk("lat_v1", out3V, 1'b0);
    in3 = 32'hBBBB_0002;
    tick();
    chk("lat_occ2", occ3, 3'd2);
    chk("lat_v2", out3V, 1'b0);
    in3 = 32'hCCCC_0003;
    tick();
    chk("lat_occ3", occ3, 3'd3);
    chk("lat_v3", out3V, 1'b1);
    chk("lat_outA", out3, 32'hAAAA_0001);
    in3 = 32'hDDDD_0004;
    tick();
    chk("lat_outB", out3, 32'hBBBB_0002);
    chk("lat_occ4", occ3, 3'd3);
    in3 = 32'hEEEE_0005;
    tick();
    chk("lat_outC", out3, 32'hCCCC_0003);
    chk("lat_occ5", occ3, 3'd3);
    in3V = 1'b0;

    // 3. Stall with DEPTH=2 holding A,B while in=D.
    in2 = 32'hAAAA_0001; in2V = 1'b1;
    tick();
    in2 = 32'hBBBB_0002;
    tick();
    chk("stl_pre_out", out2, 32'hAAAA_0001);
    chk("stl_pre_occ", occ2, 3'd2);
    in2 = 32'hDDDD_0004; st2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stl_out", out2, 32'hAAAA_0001);
      chk("stl_valid", out2V, 1'b1);
      chk("stl_occ", occ2, 3'd2);
    end
    st2 = 1'b0;
    tick();
    chk("stl_relB", out2, 32'hBBBB_0002);
    chk("stl_rel_occ", occ2, 3'd2);
    in2V = 1'b0;
    tick();
    chk("stl_relD", out2, 32'hDDDD_0004);
    chk("stl_relD_occ", occ2, 3'd1);

    // 4. Flush together with stall, partial mask. The valid input is discarded.
    in4 = PAT4; in4V = 1'b1;
    tick();
    chk("fl_pre_out", out4, PAT4);
    chk("fl_pre_occ", occ4, 3'd1);
    fl4 = 1'b1; st4 = 1'b1;
    tick();
    chk("fl_valid", out4V, 1'b0);
    chk("fl_out", out4, {32'h0000_1000, {117{1'b1}}, 17'b0});
    chk("fl_occ", occ4, 3'd0);
    fl4 = 1'b0; st4 = 1'b0;

    // 5. Bubble insertion after a valid payload.
    tick();
    chk("bub_pre_occ", occ4, 3'd1);
    in4 = '1; in4V = 1'b0;
    tick();
    chk("bub_valid", out4V, 1'b0);
    chk("bub_out", out4, {{149{1'b1}}, 17'b0});
    chk("bub_occ", occ4, 3'd0);
    tick();
    chk("bub_occ_floor", occ4, 3'd0);

    // 6. Statistics: 5 stall edges, 2 flush edges, then 1 flush+stall edge.
    st1 = 1'b1;
    repeat (5) tick();
    st1 = 1'b0; fl1 = 1'b1;
    repeat (2) tick();
    st1 = 1'b1;
    tick();
    st1 = 1'b0; fl1 = 1'b0;
    tick();
`ifdef PIPE_STATS_EN
    chk("stat_scnt", sc1, 16'd5);
    chk("stat_fcnt", fc1, 16'd3);
`else
    chk("stat_scnt", sc1, 16'd0);
    chk("stat_fcnt", fc1, 16'd0);
`endif

    // Reset asserted mid-stall takes effect without waiting for a clock edge.
    in2 = 32'h1234_5678; in2V = 1'b1;
    tick();
    tick();
    chk("ar_pre_valid", out2V, 1'b1);
    st2 = 1'b1; st1 = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_out", out2, '0);
    chk("ar_valid", out2V, 1'b0);
    chk("ar_occ", occ2, 3'd0);
    chk("ar_scnt", sc1, 16'd0);
    chk("ar_fcnt", fc1, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register. It is the successor to the fixed 166-bit ID/EX latch and is usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Adds configurable width and depth, a per-stage valid bit, stall (hold), flush (kill) and bubble insertion.
- Bubble insertion zeroes only the control bits selected by a mask, so a killed instruction cannot write registers, memory or PC.
- Sits between pipeline stages and is driven by the hazard unit's stall/flush outputs.

Parameters:
- WIDTH, 166, payload bits; bus indexed [0:WIDTH-1], bit 0 = MSB.
- DEPTH, 1, number of register stages in series (1..4); output latency in advancing cycles.
- CTL_MASK, all ones (WIDTH bits), bit set = control bit zeroed on flush/bubble; bit clear = datapath bit, left untouched.
- OCC_W, 3, width of occupancy output; must satisfy 2^OCC_W > DEPTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- in  input  WIDTH  payload from upstream stage
- in_valid  input  1  payload holds a real instruction
- stall  input  1  hold all stages
- flush  input  1  kill all stages
- out  output  WIDTH  payload of last stage
- out_valid  output  1  last stage holds a real instruction
- occupancy  output  OCC_W  count of valid stages, 0..DEPTH
- stall_cnt  output  16  stall cycles counted (PIPE_STATS_EN)
- flush_cnt  output  16  flush events counted (PIPE_STATS_EN)

Behaviour:
- State: data_q[0..DEPTH-1] (WIDTH bits each), valid_q[0..DEPTH-1], occ_q.
- Reset (reset=0, asynchronous assert; deassert takes effect at the next clk edge):
  - all data_q = 0, valid_q = 0, occ_q = 0.
  - out = 0, out_valid = 0, occupancy = 0, stall_cnt = 0, flush_cnt = 0.
  - Reset asserted mid-stall or mid-flush overrides both immediately.
- Per rising edge with reset=1, priority is flush > stall > advance.
- Flush:
  - every valid_q <= 0.
  - every data_q bit with CTL_MASK=1 <= 0; bits with CTL_MASK=0 hold.
  - occ_q <= 0.
  - flush together with stall = flush.
  - The in_valid input on a flush cycle is discarded.
- Stall (flush=0): all data_q, valid_q and occ_q hold. The input is not captured and the upstream must hold it.
- Advance (flush=0, stall=0):
  - stage 0 captures in and in_valid.
  - If in_valid=0, masked bits are captured as 0 (bubble), unmasked bits as in.
  - Stage i captures stage i-1 for i >= 1.
  - The last stage's contents are dropped (consumed downstream).
- occ_q:
  - on advance: occ_q + in_valid - valid_q[DEPTH-1].
  - never exceeds DEPTH and never underflows.
  - must always equal the popcount of valid_q; a mismatch is a bug.
- Outputs are taken directly from registers (no combinational path from in to out):
  - out = data_q[DEPTH-1], out_valid = valid_q[DEPTH-1], occupancy = occ_q.
- Invariant: whenever out_valid=0, every out bit with CTL_MASK=1 is 0.
- Latency: a payload captured at edge N appears on out after edge N+DEPTH-1 if no stall intervenes. Each stall cycle adds 1.
- DEPTH=1 with CTL_MASK all ones reproduces the legacy ID/EX register plus flush.

Optional Feature:
- Macro: PIPE_STATS_EN.
- Defined:
  - stall_cnt increments on each edge with stall=1, flush=0, reset=1.
  - flush_cnt increments on each edge with flush=1.
  - Both saturate at 16'hFFFF, do not wrap, and clear only on reset.
- Undefined: stall_cnt and flush_cnt are constant 0, no counter flops are synthesised, and ports remain present.

Test Plan:
1. Reset.
   - Stimulus: WIDTH=166, DEPTH=1, in=all ones, in_valid=1, hold reset=0 across 3 edges.
   - Required: out=0, out_valid=0 and occupancy=0 throughout; after release, one edge gives out=all ones, out_valid=1, occupancy=1.
2. Latency and occupancy.
   - Stimulus: DEPTH=3, send in=32'hA..., 32'hB..., 32'hC... (valid) on consecutive edges.
   - Required: out_valid first 1 after the 3rd edge with out=A, then B, then C; occupancy goes 1,2,3 and stays 3 while valid traffic continues.
3. Stall.
   - Stimulus: DEPTH=2 holding A,B; assert stall for 4 edges while in=D.
   - Required: out=A unchanged, occupancy=2, D not captured; after release D is output 2 edges later.
4. Flush with partial mask.
   - Stimulus: CTL_MASK sets bits 149:165 only; stage holds a valid payload with bits 149:165 all 1 and bits 0:31=32'h0000_1000; assert flush together with stall.
   - Required: out_valid=0, out[149:165]=0, out[0:31]=32'h0000_1000, occupancy=0.
5. Bubble insertion.
   - Stimulus: advance with in_valid=0 and in=all ones, DEPTH=1, mask as in test 4.
   - Required: out_valid=0, out[149:165]=0, out[0:148]=all ones, occupancy decrements by 1 if the previous stage was valid.
6. PIPE_STATS_EN.
   - Stimulus: stall for 5 edges, then flush 2 edges, then flush+stall 1 edge.
   - Required: stall_cnt=5, flush_cnt=3; with the macro undefined both read 0.
